// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM states, line levels and a width helper.
// The transmitter uses this package, and the receiver uses it as well.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Modulo-CLKS_PER_BIT counter. It ticks during the last clock of each serial bit period.
// The transmitter and the receiver both use this counter.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: a start bit, then DATA_W data bits with the LSB first, then a stop bit.
// Each bit is held for CLKS_PER_BIT clocks. tx, ready and done all come straight from registers.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              tx,
    output logic              done,
    output tx_state_t         state
);

    localparam int IW = cnt_width(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [IW-1:0]     bit_idx;
    logic              tick;

    assign shift_next = shift >> 1;

    // The timer is held at zero in IDLE, so every frame starts on a full bit period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= LINE_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift <= din;
                        state <= START;
                        tx    <= START_BIT;
                        ready <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx      <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                            tx    <= STOP_BIT;
                        end else begin
                            shift   <= shift_next;
                            tx      <= shift_next[0];
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                STOP: begin
                    // The stop bit and the IDLE level are the same, so tx does not glitch here.
                    if (tick) begin
                        state <= IDLE;
                        tx    <= LINE_IDLE;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= LINE_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx. It drives two instances: one with 4 clocks per bit and one with 1 clock per bit.
// Expected line waveforms come from the frame-format rule: a start bit, the data bits LSB first, a stop bit, each held for a fixed number of clocks.
module tb_serial_tx;
    import serial_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_a, load_b;
    logic [7:0] din_a, din_b;
    logic       ready_a, ready_b, tx_a, tx_b, done_a, done_b;
    tx_state_t  state_a, state_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .load(load_a),
        .ready(ready_a), .tx(tx_a), .done(done_a), .state(state_a)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .load(load_b),
        .ready(ready_b), .tx(tx_b), .done(done_b), .state(state_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready_a : ready_b;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    task automatic drive(input int sel, input logic l, input logic [7:0] d);
        if (sel == 0) begin
            load_a = l;
            din_a  = d;
        end else begin
            load_b = l;
            din_b  = d;
        end
    endtask

    task automatic idle_check(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_tx[%0d]", sel), 8'(get_tx(sel)), 8'd1);
            check($sformatf("idle_ready[%0d]", sel), 8'(get_ready(sel)), 8'd1);
            check($sformatf("idle_done[%0d]", sel), 8'(get_done(sel)), 8'd0);
        end
    endtask

    // Sends one frame and checks it cycle by cycle against the frame-format rule.
    // A stray load with din=3C is pulsed mid-frame, and din is scrambled while the frame is in flight.
    task automatic frame(input int sel, input logic [7:0] data, input bit preloaded,
                         input bit keep_load, input bit next_load, input logic [7:0] next_din);
        int cpb;
        int f;
        logic exp_bits[$];
        cpb = (sel == 0) ? 4 : 1;
        f = 10 * cpb;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
        exp_bits.push_back(1'b1);
        if (!preloaded) begin
            @(negedge clk);
            check($sformatf("pre_ready[%0d]", sel), 8'(get_ready(sel)), 8'd1);
            check($sformatf("pre_tx[%0d]", sel), 8'(get_tx(sel)), 8'd1);
            drive(sel, 1'b1, data);
        end
        for (int c = 1; c <= f; c++) begin
            @(negedge clk);
            check($sformatf("tx[%0d] data=%02h cyc=%0d", sel, data, c),
                  8'(get_tx(sel)), 8'(exp_bits[(c - 1) / cpb]));
            check($sformatf("busy_ready[%0d] cyc=%0d", sel, c), 8'(get_ready(sel)), 8'd0);
            check($sformatf("busy_done[%0d] cyc=%0d", sel, c), 8'(get_done(sel)), 8'd0);
            drive(sel, keep_load || (c == 3), (c == 3) ? 8'h3C : 8'($urandom));
        end
        @(negedge clk);
        check($sformatf("done[%0d] data=%02h", sel, data), 8'(get_done(sel)), 8'd1);
        check($sformatf("done_ready[%0d]", sel), 8'(get_ready(sel)), 8'd1);
        check($sformatf("done_tx[%0d]", sel), 8'(get_tx(sel)), 8'd1);
        drive(sel, next_load, next_din);
    endtask

    initial begin
        logic frame_bits[$];
        reset = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check("reset_state_a", 8'(state_a), 8'(IDLE));
        check("reset_tx_a", 8'(tx_a), 8'd1);
        check("reset_ready_a", 8'(ready_a), 8'd1);
        check("reset_done_a", 8'(done_a), 8'd0);
        check("reset_tx_b", 8'(tx_b), 8'd1);
        reset = 1'b0;

        idle_check(0, 20);
        idle_check(1, 2);

        frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_check(0, 3);

        // Load held high: the second frame is accepted in the done cycle of the first.
        frame(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF);
        frame(0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        idle_check(0, 3);

        frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_check(0, 5);

        // Reset in the middle of a 0x55 frame.
        frame_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) frame_bits.push_back(i[0] == 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 8'h55);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check($sformatf("pre_abort_tx cyc=%0d", c), 8'(tx_a), 8'(frame_bits[(c - 1) / 4]));
            check("pre_abort_ready", 8'(ready_a), 8'd0);
            drive(0, 1'b0, 8'($urandom));
        end
        reset = 1'b1;
        #1;
        check("abort_tx", 8'(tx_a), 8'd1);
        check("abort_ready", 8'(ready_a), 8'd1);
        check("abort_done", 8'(done_a), 8'd0);
        check("abort_state", 8'(state_a), 8'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        idle_check(0, 4);
        frame(0, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_check(0, 2);

        frame(1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_check(1, 3);
        frame(1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h96);
        frame(1, 8'h96, 1'b1, 1'b0, 1'b0, 8'h00);
        idle_check(1, 2);

        for (int i = 0; i < 4; i++) begin
            frame(0, 8'($urandom), 1'b0, 1'b0, 1'b0, 8'h00);
            idle_check(0, 1 + $urandom_range(0, 2));
            frame(1, 8'($urandom), 1'b0, 1'b0, 1'b0, 8'h00);
            idle_check(1, 1 + $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
